// File: rtl/sram_pkg.sv
// Shared helpers for the behavioural SRAM family: address sizing, latency
// range check and the per-granule merge used by write and read paths.
package sram_pkg;

    // Widest word the merge helper handles; instantiations above this are rejected.
    localparam int MERGE_W  = 1024;
    localparam int MERGE_AW = 10;

    typedef logic [MERGE_W-1:0] merge_vec_t;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return result;
    endfunction

    // Only one or two cycles of read latency are modelled.
    function automatic bit latency_ok(input int latency);
        return (latency == 1) || (latency == 2);
    endfunction

    // Take each granule from new_w where its mask bit is set, else from old_w.
    // Mask bit g covers bits [g*gran_w +: gran_w].
    function automatic merge_vec_t merge(input merge_vec_t old_w,
                                         input merge_vec_t new_w,
                                         input merge_vec_t mask,
                                         input int         gran_w);
        merge_vec_t result;
        result = old_w;
        for (int b = 0; b < MERGE_W; b++) begin
            if (mask[MERGE_AW'(b / gran_w)]) begin
                result[MERGE_AW'(b)] = new_w[MERGE_AW'(b)];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Optional extra read-output register stage with its own valid bit.
// STAGES=0 is a wire-through; STAGES=1 adds one register with sync clear.
module sram_rd_pipe #(
    parameter int DATA_W = 64,
    parameter int STAGES = 0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    if (STAGES == 0) begin : g_pass
        // Clock and clear have no job when the stage is absent.
        logic unused_pass;
        assign unused_pass = clock ^ reset_n;
        assign out_valid   = in_valid;
        assign out_data    = in_data;
    end else if (STAGES == 1) begin : g_reg
        logic              valid_d, valid_q;
        logic [DATA_W-1:0] data_d, data_q;

        // Capture only on a valid word so the output holds between reads.
        always_comb begin
            valid_d = in_valid;
            data_d  = in_valid ? in_data : data_q;
        end

        // Output register, cleared synchronously so in-flight reads are dropped.
        always_ff @(posedge clock) begin
            if (!reset_n) begin
                valid_q <= 1'b0;
                data_q  <= '0;
            end else begin
                valid_q <= valid_d;
                data_q  <= data_d;
            end
        end

        assign out_valid = valid_q;
        assign out_data  = data_q;
    end else begin : g_bad_stages
        $error("sram_rd_pipe: STAGES must be 0 or 1");
    end

endmodule

// File: rtl/sram_1r1w_ext.sv
// Behavioural 1-read/1-write SRAM with per-granule write mask, read-as-zero
// for never-written granules, selectable same-address bypass and a read-valid
// strobe. Read latency of 1 or 2 cycles.
module sram_1r1w_ext
    import sram_pkg::*;
#(
    parameter  int DATA_W       = 64,
    parameter  int DEPTH        = 512,
    parameter  int GRAN_W       = 8,
    parameter  int READ_LATENCY = 1,
    parameter  int BYPASS       = 1,
    localparam int ADDR_W       = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH),
    localparam int NGRAN        = DATA_W / GRAN_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              W0_en,
    input  logic [ADDR_W-1:0] W0_addr,
    input  logic [DATA_W-1:0] W0_data,
    input  logic [NGRAN-1:0]  W0_mask,
    input  logic              R0_en,
    input  logic [ADDR_W-1:0] R0_addr,
    output logic [DATA_W-1:0] R0_data,
    output logic              R0_valid
);

    // Elaboration-time parameter checks.
    if (GRAN_W < 1) begin : g_bad_gran_zero
        $error("sram_1r1w_ext: GRAN_W must be positive");
    end else if ((DATA_W % GRAN_W) != 0) begin : g_bad_gran
        $error("sram_1r1w_ext: GRAN_W must divide DATA_W");
    end
    if (!latency_ok(READ_LATENCY)) begin : g_bad_latency
        $error("sram_1r1w_ext: READ_LATENCY must be 1 or 2");
    end
    if (DATA_W > MERGE_W) begin : g_bad_width
        $error("sram_1r1w_ext: DATA_W exceeds merge helper width");
    end

    // DEPTH need not be a power of two, so addresses are range-checked.
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem_q  [DEPTH];
    logic [NGRAN-1:0]  flag_q [DEPTH];

    logic              wr_in_range, rd_in_range;
    logic [ADDR_W-1:0] wr_idx, rd_idx;
    logic              wr_fire, bypass_hit;
    merge_vec_t        wr_merged, rd_zeroed, rd_bypassed;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] rd_data_d, rd_data_q;
    logic              rd_valid_d, rd_valid_q;

    // Decode write, resolve the read word (zeroing, bypass) and next read regs.
    // NOTE: every variable gets a value on every path here, so no latches are inferred.
    always_comb begin
        wr_in_range = ({1'b0, W0_addr} < DEPTH_L);
        rd_in_range = ({1'b0, R0_addr} < DEPTH_L);
        // Clamp indices so out-of-range addresses never touch the arrays.
        wr_idx      = wr_in_range ? W0_addr : '0;
        rd_idx      = rd_in_range ? R0_addr : '0;
        // A write sharing an edge with reset is dropped.
        wr_fire     = reset_n && W0_en && wr_in_range;

        wr_merged   = merge(merge_vec_t'(mem_q[wr_idx]), merge_vec_t'(W0_data),
                            merge_vec_t'(W0_mask), GRAN_W);

        // Granules whose written-flag is clear read as zero.
        rd_zeroed   = merge('0, merge_vec_t'(mem_q[rd_idx]),
                            merge_vec_t'(flag_q[rd_idx]), GRAN_W);

        // Same-address forwarding of the masked granules being written this edge.
        bypass_hit  = (BYPASS != 0) && wr_fire && rd_in_range && (W0_addr == R0_addr);
        rd_bypassed = bypass_hit
                    ? merge(rd_zeroed, merge_vec_t'(W0_data), merge_vec_t'(W0_mask), GRAN_W)
                    : rd_zeroed;

        rd_word     = rd_in_range ? rd_bypassed[DATA_W-1:0] : '0;

        rd_data_d   = R0_en ? rd_word : rd_data_q;
        rd_valid_d  = R0_en;
    end

    // Masked write into the data array.
    // NOTE: the data array has no reset; the written-flags make stale contents invisible.
    always_ff @(posedge clock) begin
        if (wr_fire) begin
            mem_q[wr_idx] <= wr_merged[DATA_W-1:0];
        end
    end

    // Written-flags: cleared by reset, set per masked granule on a write.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                flag_q[i] <= '0;
            end
        end else if (wr_fire) begin
            flag_q[wr_idx] <= flag_q[wr_idx] | W0_mask;
        end
    end

    // First read stage: word and valid registered at the R0_en edge.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    sram_rd_pipe #(
        .DATA_W (DATA_W),
        .STAGES (READ_LATENCY - 1)
    ) u_rd_pipe (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (rd_valid_q),
        .in_data   (rd_data_q),
        .out_valid (R0_valid),
        .out_data  (R0_data)
    );

endmodule

// File: tb/tb_sram_1r1w_ext.sv
// Directed bench for sram_1r1w_ext. Instance A: 64b x 512, latency 1, bypass.
// Instance B: 64b x 500, latency 2, no bypass.
module tb_sram_1r1w_ext;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    logic        a_rst_n, a_w_en, a_r_en, a_r_valid;
    logic [8:0]  a_w_addr, a_r_addr;
    logic [63:0] a_w_data, a_r_data;
    logic [7:0]  a_w_mask;

    logic        b_rst_n, b_w_en, b_r_en, b_r_valid;
    logic [8:0]  b_w_addr, b_r_addr;
    logic [63:0] b_w_data, b_r_data;
    logic [7:0]  b_w_mask;

    sram_1r1w_ext #(
        .DATA_W(64), .DEPTH(512), .GRAN_W(8), .READ_LATENCY(1), .BYPASS(1)
    ) u_dut_a (
        .clock(clock), .reset_n(a_rst_n),
        .W0_en(a_w_en), .W0_addr(a_w_addr), .W0_data(a_w_data), .W0_mask(a_w_mask),
        .R0_en(a_r_en), .R0_addr(a_r_addr), .R0_data(a_r_data), .R0_valid(a_r_valid)
    );

    sram_1r1w_ext #(
        .DATA_W(64), .DEPTH(500), .GRAN_W(8), .READ_LATENCY(2), .BYPASS(0)
    ) u_dut_b (
        .clock(clock), .reset_n(b_rst_n),
        .W0_en(b_w_en), .W0_addr(b_w_addr), .W0_data(b_w_data), .W0_mask(b_w_mask),
        .R0_en(b_r_en), .R0_addr(b_r_addr), .R0_data(b_r_data), .R0_valid(b_r_valid)
    );

    function automatic logic [63:0] b2b_word(input int i);
        return 64'h0101010101010101 * 64'(i + 16);
    endfunction

    // One write cycle on the selected instances, then writes deasserted.
    task automatic do_write(input bit to_a, input bit to_b, input logic [8:0] addr,
                            input logic [63:0] data, input logic [7:0] mask);
        @(negedge clock);
        if (to_a) begin a_w_en = 1'b1; a_w_addr = addr; a_w_data = data; a_w_mask = mask; end
        if (to_b) begin b_w_en = 1'b1; b_w_addr = addr; b_w_data = data; b_w_mask = mask; end
        @(negedge clock);
        a_w_en = 1'b0;
        b_w_en = 1'b0;
    endtask

    task automatic read_a(input logic [8:0] addr, output logic [63:0] data, output logic valid);
        @(negedge clock);
        a_r_en = 1'b1; a_r_addr = addr;
        @(negedge clock);
        a_r_en = 1'b0;
        data = a_r_data; valid = a_r_valid;
    endtask

    task automatic read_b(input logic [8:0] addr, output logic [63:0] data, output logic valid);
        @(negedge clock);
        b_r_en = 1'b1; b_r_addr = addr;
        @(negedge clock);
        b_r_en = 1'b0;
        @(negedge clock);
        data = b_r_data; valid = b_r_valid;
    endtask

    task automatic test_reset();
        a_rst_n = 1'b0; b_rst_n = 1'b0;
        repeat (2) @(negedge clock);
        n_checks++; if (a_r_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid_a: got %b want 0", a_r_valid); end
        n_checks++; if (a_r_data !== 64'h0) begin n_fail++; $display("FAIL reset_data_a: got %h want 0", a_r_data); end
        n_checks++; if (b_r_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid_b: got %b want 0", b_r_valid); end
        n_checks++; if (b_r_data !== 64'h0) begin n_fail++; $display("FAIL reset_data_b: got %h want 0", b_r_data); end
        a_rst_n = 1'b1; b_rst_n = 1'b1;
    endtask

    task automatic test_read_unwritten();
        // Latency 1: valid one cycle after the request, then drops.
        @(negedge clock); a_r_en = 1'b1; a_r_addr = 9'd5;
        @(negedge clock); a_r_en = 1'b0;
        n_checks++; if (a_r_valid !== 1'b1) begin n_fail++; $display("FAIL unwritten_valid_a: got %b want 1", a_r_valid); end
        n_checks++; if (a_r_data !== 64'h0) begin n_fail++; $display("FAIL unwritten_data_a: got %h want 0", a_r_data); end
        @(negedge clock);
        n_checks++; if (a_r_valid !== 1'b0) begin n_fail++; $display("FAIL strobe_len_a: got %b want 0", a_r_valid); end
        // Latency 2: nothing after one cycle, valid after two.
        @(negedge clock); b_r_en = 1'b1; b_r_addr = 9'd5;
        @(negedge clock); b_r_en = 1'b0;
        n_checks++; if (b_r_valid !== 1'b0) begin n_fail++; $display("FAIL early_valid_b: got %b want 0", b_r_valid); end
        @(negedge clock);
        n_checks++; if (b_r_valid !== 1'b1) begin n_fail++; $display("FAIL unwritten_valid_b: got %b want 1", b_r_valid); end
        n_checks++; if (b_r_data !== 64'h0) begin n_fail++; $display("FAIL unwritten_data_b: got %h want 0", b_r_data); end
        @(negedge clock);
        n_checks++; if (b_r_valid !== 1'b0) begin n_fail++; $display("FAIL strobe_len_b: got %b want 0", b_r_valid); end
    endtask

    task automatic test_masked_write();
        logic [63:0] d;
        logic        v;
        // Write then read the very next cycle.
        @(negedge clock);
        a_w_en = 1'b1; a_w_addr = 9'd3; a_w_data = 64'h1122334455667788; a_w_mask = 8'h0F;
        b_w_en = 1'b1; b_w_addr = 9'd3; b_w_data = 64'h1122334455667788; b_w_mask = 8'h0F;
        @(negedge clock);
        a_w_en = 1'b0; b_w_en = 1'b0;
        a_r_en = 1'b1; a_r_addr = 9'd3;
        b_r_en = 1'b1; b_r_addr = 9'd3;
        @(negedge clock);
        a_r_en = 1'b0; b_r_en = 1'b0;
        n_checks++; if (a_r_data !== 64'h0000000055667788) begin n_fail++; $display("FAIL mask_low_a: got %h want 0000000055667788", a_r_data); end
        @(negedge clock);
        n_checks++; if (b_r_data !== 64'h0000000055667788) begin n_fail++; $display("FAIL mask_low_b: got %h want 0000000055667788", b_r_data); end
        // Upper granules filled, lower ones untouched.
        do_write(1'b1, 1'b1, 9'd3, 64'hAABBCCDDEEFF0011, 8'hF0);
        // All-zero mask must not change anything.
        do_write(1'b1, 1'b1, 9'd3, 64'hFFFFFFFFFFFFFFFF, 8'h00);
        read_a(9'd3, d, v);
        n_checks++; if (d !== 64'hAABBCCDD55667788) begin n_fail++; $display("FAIL mask_merge_a: got %h want aabbccdd55667788", d); end
        read_b(9'd3, d, v);
        n_checks++; if (d !== 64'hAABBCCDD55667788) begin n_fail++; $display("FAIL mask_merge_b: got %h want aabbccdd55667788", d); end
    endtask

    task automatic test_bypass();
        logic [63:0] d;
        logic        v;
        do_write(1'b1, 1'b1, 9'd3, 64'hAAAAAAAAAAAAAAAA, 8'hFF);
        // Same-edge write and read of address 3.
        @(negedge clock);
        a_w_en = 1'b1; a_w_addr = 9'd3; a_w_data = 64'hFFFFFFFFFFFFFFFF; a_w_mask = 8'h01;
        b_w_en = 1'b1; b_w_addr = 9'd3; b_w_data = 64'hFFFFFFFFFFFFFFFF; b_w_mask = 8'h01;
        a_r_en = 1'b1; a_r_addr = 9'd3;
        b_r_en = 1'b1; b_r_addr = 9'd3;
        @(negedge clock);
        a_w_en = 1'b0; b_w_en = 1'b0; a_r_en = 1'b0; b_r_en = 1'b0;
        n_checks++; if (a_r_data !== 64'hAAAAAAAAAAAAAAFF) begin n_fail++; $display("FAIL bypass_new_a: got %h want aaaaaaaaaaaaaaff", a_r_data); end
        @(negedge clock);
        n_checks++; if (b_r_data !== 64'hAAAAAAAAAAAAAAAA) begin n_fail++; $display("FAIL bypass_old_b: got %h want aaaaaaaaaaaaaaaa", b_r_data); end
        // The write is visible to later reads in both modes.
        read_a(9'd3, d, v);
        n_checks++; if (d !== 64'hAAAAAAAAAAAAAAFF) begin n_fail++; $display("FAIL after_bypass_a: got %h want aaaaaaaaaaaaaaff", d); end
        read_b(9'd3, d, v);
        n_checks++; if (d !== 64'hAAAAAAAAAAAAAAFF) begin n_fail++; $display("FAIL after_bypass_b: got %h want aaaaaaaaaaaaaaff", d); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            a_w_en = 1'b1; a_w_addr = 9'(i); a_w_data = b2b_word(i); a_w_mask = 8'hFF;
            b_w_en = 1'b1; b_w_addr = 9'(i); b_w_data = b2b_word(i); b_w_mask = 8'hFF;
        end
        @(negedge clock);
        a_w_en = 1'b0; b_w_en = 1'b0;
        // Reads of 0..7 on eight consecutive edges; check each negedge, then drive.
        for (int k = 0; k < 11; k++) begin
            @(negedge clock);
            n_checks++;
            if (a_r_valid !== ((k >= 1) && (k <= 8))) begin
                n_fail++; $display("FAIL b2b_valid_a[%0d]: got %b", k, a_r_valid);
            end
            if ((k >= 1) && (k <= 8)) begin
                n_checks++;
                if (a_r_data !== b2b_word(k - 1)) begin
                    n_fail++; $display("FAIL b2b_data_a[%0d]: got %h want %h", k, a_r_data, b2b_word(k - 1));
                end
            end
            n_checks++;
            if (b_r_valid !== ((k >= 2) && (k <= 9))) begin
                n_fail++; $display("FAIL b2b_valid_b[%0d]: got %b", k, b_r_valid);
            end
            if ((k >= 2) && (k <= 9)) begin
                n_checks++;
                if (b_r_data !== b2b_word(k - 2)) begin
                    n_fail++; $display("FAIL b2b_data_b[%0d]: got %h want %h", k, b_r_data, b2b_word(k - 2));
                end
            end
            a_r_en = (k < 8); a_r_addr = 9'(k);
            b_r_en = (k < 8); b_r_addr = 9'(k);
        end
    endtask

    task automatic test_out_of_range();
        logic [63:0] d;
        logic        v;
        // B has 500 words: 505 is out of range.
        do_write(1'b0, 1'b1, 9'd505, 64'hDEADBEEFCAFEF00D, 8'hFF);
        read_b(9'd505, d, v);
        n_checks++; if (v !== 1'b1) begin n_fail++; $display("FAIL oor_valid_b: got %b want 1", v); end
        n_checks++; if (d !== 64'h0) begin n_fail++; $display("FAIL oor_data_b: got %h want 0", d); end
        // No wrap-around into low addresses.
        read_b(9'd5, d, v);
        n_checks++; if (d !== b2b_word(5)) begin n_fail++; $display("FAIL oor_alias_b: got %h want %h", d, b2b_word(5)); end
        // Last word of A is in range.
        do_write(1'b1, 1'b0, 9'd511, 64'h0123456789ABCDEF, 8'hFF);
        read_a(9'd511, d, v);
        n_checks++; if (d !== 64'h0123456789ABCDEF) begin n_fail++; $display("FAIL top_addr_a: got %h want 0123456789abcdef", d); end
    endtask

    task automatic test_reset_in_flight();
        logic [63:0] d;
        logic        v;
        @(negedge clock); b_r_en = 1'b1; b_r_addr = 9'd3;
        @(negedge clock);
        b_r_en = 1'b0; b_rst_n = 1'b0;
        // A write during reset must be ignored.
        b_w_en = 1'b1; b_w_addr = 9'd7; b_w_data = 64'h5555555555555555; b_w_mask = 8'hFF;
        @(negedge clock);
        n_checks++; if (b_r_valid !== 1'b0) begin n_fail++; $display("FAIL flight_valid0_b: got %b want 0", b_r_valid); end
        n_checks++; if (b_r_data !== 64'h0) begin n_fail++; $display("FAIL flight_data_b: got %h want 0", b_r_data); end
        b_rst_n = 1'b1; b_w_en = 1'b0;
        @(negedge clock);
        n_checks++; if (b_r_valid !== 1'b0) begin n_fail++; $display("FAIL flight_valid1_b: got %b want 0", b_r_valid); end
        read_b(9'd3, d, v);
        n_checks++; if (d !== 64'h0) begin n_fail++; $display("FAIL flags_cleared_b: got %h want 0", d); end
        read_b(9'd7, d, v);
        n_checks++; if (d !== 64'h0) begin n_fail++; $display("FAIL write_in_reset_b: got %h want 0", d); end
    endtask

    initial begin
        a_rst_n = 1'b0; a_w_en = 1'b0; a_r_en = 1'b0;
        a_w_addr = '0; a_w_data = '0; a_w_mask = '0; a_r_addr = '0;
        b_rst_n = 1'b0; b_w_en = 1'b0; b_r_en = 1'b0;
        b_w_addr = '0; b_w_data = '0; b_w_mask = '0; b_r_addr = '0;
        test_reset();
        test_read_unwritten();
        test_masked_write();
        test_bypass();
        test_back_to_back();
        test_out_of_range();
        test_reset_in_flight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
